// File: rtl/min_cost_list_store_pkg.sv
// Shared definitions for the minimum-cost tied-list store.
//   - state_t and its IDLE / COLLECT / DRAIN encodings
//   - list_entry(): extracts entry k from a packed assignment list whose
//     entry 0 sits in the most significant IDXW bits.
package min_cost_list_store_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t COLLECT = 2'd1;
  localparam state_t DRAIN   = 2'd2;

  // Widest packed list the helper accepts; narrower lists are zero-extended.
  localparam int LIST_MAXW = 256;

  function automatic logic [15:0] list_entry(input logic [LIST_MAXW-1:0] list,
                                             input int unsigned n,
                                             input int unsigned idxw,
                                             input int unsigned k);
    logic [LIST_MAXW-1:0] shifted;
    shifted = list >> ((n - 1 - k) * idxw);
    return 16'(shifted) & ((16'd1 << idxw) - 16'd1);
  endfunction

endpackage

// File: rtl/min_cost_list_store_list_regfile.sv
// DEPTH x W register file holding the tied assignment lists.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears every slot)
//   clear_all     clear every slot
//   clear_rest    clear slots 1..DEPTH-1; slot0 may be written in the same cycle
//   wr_en/addr/data  single write port
//   rd_addr/rd_data  asynchronous read port (zero for out-of-range addresses)
module min_cost_list_store_list_regfile #(
  parameter int DEPTH = 10,
  parameter int W     = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_all,
  input  logic          clear_rest,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the slots are reset explicitly because a drained or restarted
  // search must never expose lists from a previous search.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear_rest && i != 0)
          mem[i] <= '0;
        else if (wr_en && wr_addr == AW'(i))
          mem[i] <= wr_data;
      end
    end
  end

  assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/min_cost_list_store.sv
// Keeps every assignment list tied at the running minimum cost (up to DEPTH
// of them) and streams them out with valid/ready once the search ends.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   start                    clear store/minimum and begin a search
//   cand_valid/list/cost     candidate from the evaluator
//   search_done              evaluator finished; begin drain
//   min_cost, match_count    running minimum and number of stored lists
//   overflow                 a tied list was dropped in this search
//   busy                     COLLECT or DRAIN
//   out_valid/ready/list/last  drain handshake
//   done                     one-cycle pulse when the drain completes
module min_cost_list_store
  import min_cost_list_store_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDXW  = 3,
  parameter int DEPTH = 10,
  parameter int COSTW = 10,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               cand_valid,
  input  logic [N*IDXW-1:0]  cand_list,
  input  logic [COSTW-1:0]   cand_cost,
  input  logic               search_done,
  output logic [COSTW-1:0]   min_cost,
  output logic [CNTW-1:0]    match_count,
  output logic               overflow,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*IDXW-1:0]  out_list,
  output logic               out_last,
  output logic               done
);

  localparam int LW = N * IDXW;
  localparam int AW = $clog2(DEPTH);

  state_t          state;
  logic [CNTW-1:0] rd_ptr;
  logic [LW-1:0]   rd_data;
  logic            take, is_lower, is_tie, is_drop;
  logic [CNTW-1:0] count_next;

  // A candidate is only considered in COLLECT, and start overrides it.
  assign take     = cand_valid && state == COLLECT && !start;
  assign is_lower = take && cand_cost < min_cost;
  assign is_tie   = take && cand_cost == min_cost && match_count < CNTW'(DEPTH);
  assign is_drop  = take && cand_cost == min_cost && match_count == CNTW'(DEPTH);

  // Count including this cycle's candidate; search_done in the same cycle
  // must see it so a last-cycle tie is still drained.
  always_comb begin
    count_next = match_count;
    if (is_lower)    count_next = CNTW'(1);
    else if (is_tie) count_next = match_count + CNTW'(1);
  end

  min_cost_list_store_list_regfile #(.DEPTH(DEPTH), .W(LW), .AW(AW)) u_regfile (
    .clk        (CLK),
    .rst        (RST),
    .clear_all  (start),
    .clear_rest (is_lower),
    .wr_en      (is_lower || is_tie),
    .wr_addr    (is_lower ? '0 : AW'(match_count)),
    .wr_data    (cand_list),
    .rd_addr    (AW'(rd_ptr)),
    .rd_data    (rd_data)
  );

  assign busy      = state != IDLE;
  assign out_valid = state == DRAIN;
  assign out_list  = out_valid ? rd_data : '0;
  assign out_last  = out_valid && rd_ptr == match_count - CNTW'(1);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      min_cost    <= '1;
      match_count <= '0;
      overflow    <= 1'b0;
      rd_ptr      <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= COLLECT;
        min_cost    <= '1;
        match_count <= '0;
        overflow    <= 1'b0;
        rd_ptr      <= '0;
      end else begin
        case (state)
          COLLECT: begin
            match_count <= count_next;
            if (is_lower) begin
              min_cost <= cand_cost;
              overflow <= 1'b0;
            end else if (is_drop) begin
              overflow <= 1'b1;
            end
            if (search_done) begin
              rd_ptr <= '0;
              if (count_next != '0) begin
                state <= DRAIN;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (out_ready) begin
              rd_ptr <= rd_ptr + CNTW'(1);
              if (out_last) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_min_cost_list_store.sv
module tb_min_cost_list_store;

  localparam int N     = 8;
  localparam int IDXW  = 3;
  localparam int DEPTH = 10;
  localparam int COSTW = 10;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int LW    = N * IDXW;
  localparam logic [COSTW-1:0] MAXC = '1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             cand_valid = 1'b0;
  logic [LW-1:0]    cand_list = '0;
  logic [COSTW-1:0] cand_cost = '0;
  logic             search_done = 1'b0;
  logic [COSTW-1:0] min_cost;
  logic [CNTW-1:0]  match_count;
  logic             overflow, busy, out_valid, out_last, done;
  logic             out_ready = 1'b0;
  logic [LW-1:0]    out_list;

  min_cost_list_store #(.N(N), .IDXW(IDXW), .DEPTH(DEPTH), .COSTW(COSTW), .CNTW(CNTW)) dut (
    .CLK(clk), .RST(rst), .start(start), .cand_valid(cand_valid), .cand_list(cand_list),
    .cand_cost(cand_cost), .search_done(search_done), .min_cost(min_cost),
    .match_count(match_count), .overflow(overflow), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_list(out_list), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the search as a queue of tied lists.
  logic [LW-1:0]    m_q[$];
  logic [COSTW-1:0] m_min = '1;
  bit               m_ovf = 0;
  bit               m_collect = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".min"},   32'(min_cost),    32'(m_min));
    check({tag, ".count"}, 32'(match_count), 32'(m_q.size()));
    check({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
  endtask

  task automatic check_idle_reset(input string tag);
    check_state(tag);
    check({tag, ".busy"},  32'(busy),      0);
    check({tag, ".valid"}, 32'(out_valid), 0);
    check({tag, ".list"},  32'(out_list),  0);
    check({tag, ".last"},  32'(out_last),  0);
    check({tag, ".done"},  32'(done),      0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 0; cand_valid = 0; search_done = 0; out_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    m_q.delete(); m_min = '1; m_ovf = 0; m_collect = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_q.delete(); m_min = '1; m_ovf = 0; m_collect = 1;
    check_state("start");
    check("start.busy", 32'(busy), 1);
  endtask

  // One candidate this cycle, optionally together with search_done.
  task automatic send(input logic [LW-1:0] l, input logic [COSTW-1:0] c, input bit sd);
    cand_valid = 1'b1; cand_list = l; cand_cost = c; search_done = sd;
    @(negedge clk);
    cand_valid = 1'b0; search_done = 1'b0;
    if (m_collect) begin
      if (c < m_min) begin
        m_q.delete(); m_q.push_back(l); m_min = c; m_ovf = 0;
      end else if (c == m_min) begin
        if (m_q.size() < DEPTH) m_q.push_back(l);
        else m_ovf = 1;
      end
      if (sd) m_collect = 0;
    end
    check_state("cand");
  endtask

  task automatic end_search();
    search_done = 1'b1;
    @(negedge clk);
    search_done = 1'b0;
    m_collect = 0;
  endtask

  // Drain the expected queue. ready bits come from pat (LSB first) when
  // use_pat is set, otherwise from $urandom.
  task automatic drain(input logic [31:0] pat, input bit use_pat);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    if (m_q.size() == 0) begin
      check("empty.done",  32'(done),      1);
      check("empty.valid", 32'(out_valid), 0);
      @(negedge clk);
      check("empty.done_off", 32'(done),   0);
      check("empty.valid2",   32'(out_valid), 0);
      return;
    end
    while (idx < m_q.size()) begin
      if (cyc > 300) begin
        check("drain.timeout", 32'(idx), 32'(m_q.size()));
        return;
      end
      check("drain.valid", 32'(out_valid), 1);
      check("drain.list",  32'(out_list),  32'(m_q[idx]));
      check("drain.last",  32'(out_last),  32'(idx == m_q.size() - 1));
      check("drain.done",  32'(done),      0);
      rdy = (use_pat && cyc < 32) ? pat[cyc] : 1'($urandom);
      out_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain.done_pulse", 32'(done),      1);
    check("drain.valid_off",  32'(out_valid), 0);
    check("drain.busy_off",   32'(busy),      0);
    check_state("drain.hold");
    @(negedge clk);
    check("drain.done_off", 32'(done), 0);
  endtask

  function automatic logic [LW-1:0] rand_list();
    return LW'($urandom);
  endfunction

  initial begin
    logic [LW-1:0] l;
    do_reset();
    check_idle_reset("reset");

    // Strictly decreasing costs.
    do_start();
    send(rand_list(), 10'd50, 0);
    send(rand_list(), 10'd40, 0);
    send(rand_list(), 10'd30, 0);
    end_search();
    drain(32'hFFFF_FFFF, 1);

    // Candidates in IDLE are ignored.
    send(rand_list(), 10'd1, 0);

    // Ties, then a new lower minimum.
    do_start();
    send(rand_list(), 10'd20, 0);
    send(rand_list(), 10'd20, 0);
    send(rand_list(), 10'd20, 0);
    send(rand_list(), 10'd15, 0);
    send(rand_list(), 10'd15, 0);
    end_search();
    drain(32'hFFFF_FFFF, 1);

    // Overflow, then recovery via a lower cost.
    do_start();
    for (int i = 0; i < DEPTH + 2; i++) send(rand_list(), 10'd7, 0);
    check("ovf.flag", 32'(overflow), 1);
    send(rand_list(), 10'd6, 0);
    check("ovf.cleared", 32'(overflow), 0);
    end_search();
    drain(32'hFFFF_FFFF, 1);

    // Back-pressure with ready pattern 1,0,0,1,1.
    do_start();
    for (int i = 0; i < 3; i++) send(rand_list(), 10'd5, 0);
    end_search();
    drain(32'b11001, 1);

    // Tie arriving together with search_done; first cost of all ones.
    do_start();
    send(rand_list(), MAXC, 0);
    send(rand_list(), MAXC, 1);
    drain(32'hFFFF_FFFF, 1);

    // search_done with nothing stored.
    do_start();
    end_search();
    drain(32'h0, 1);

    // start mid-COLLECT.
    do_start();
    send(rand_list(), 10'd3, 0);
    send(rand_list(), 10'd3, 0);
    do_start();
    check("restart.min", 32'(min_cost), 32'(MAXC));
    check("restart.count", 32'(match_count), 0);

    // RST mid-DRAIN.
    for (int i = 0; i < 3; i++) send(rand_list(), 10'd9, 0);
    end_search();
    check("rstdrain.valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_q.delete(); m_min = '1; m_ovf = 0; m_collect = 0;
    check_idle_reset("rstdrain");
    @(negedge clk);
    check("rstdrain.no_done", 32'(done), 0);

    // Randomized searches.
    for (int r = 0; r < 20; r++) begin
      int n;
      bit last_sd;
      do_start();
      n = $urandom_range(0, 16);
      last_sd = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        l = rand_list();
        send(l, ($urandom_range(0, 7) == 0) ? MAXC : COSTW'($urandom_range(0, 3)),
             (i == n - 1) && last_sd);
      end
      if (!(n > 0 && last_sd)) end_search();
      drain(32'h0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/min_cost_list_store.md
# min_cost_list_store

Parametrised store for assignment lists that tie at the current minimum cost. It sits between the permutation/cost evaluator and the result output stage of the transportation-problem solver. It tracks the running minimum cost internally and keeps up to DEPTH tied lists. When the search ends, it streams the kept lists out with a valid/ready handshake and reports an overflow when more ties arrived than it could store.

## Interface
- N, 8: entries per assignment list (workers/jobs)
- IDXW, 3: bits per list entry; must satisfy 2^IDXW ≥ N
- DEPTH, 10: maximum stored tied lists (≥ 2)
- COSTW, 10: cost width
- CNTW, $clog2(DEPTH+1): width of match_count

- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  clear store and minimum; begin a new search
- cand_valid  in  1  candidate list and cost present this cycle
- cand_list  in  N*IDXW  candidate list; entry k at [N*IDXW-1-k*IDXW -: IDXW]
- cand_cost  in  COSTW  total cost of the candidate
- search_done  in  1  evaluator finished; begin drain
- min_cost  out  COSTW  current minimum cost
- match_count  out  CNTW  number of stored lists
- overflow  out  1  a tied list was dropped in this search
- busy  out  1  state is COLLECT or DRAIN
- out_valid  out  1  out_list holds a stored list
- out_ready  in  1  consumer accepts out_list
- out_list  out  N*IDXW  stored list at the read pointer, same packing as cand_list
- out_last  out  1  out_list is the final stored list
- done  out  1  one-cycle pulse when the drain completes

## Operation
- States:
  - IDLE: no search in progress.
  - COLLECT: accepting candidates.
  - DRAIN: streaming stored lists to the consumer.
- start, in any state:
  - next state COLLECT;
  - min_cost ← all ones; match_count ← 0; overflow ← 0; read pointer ← 0;
  - every stored slot ← 0.
- start has priority over every other input in the same cycle.
- COLLECT, when cand_valid = 1 (unsigned compare of cand_cost against min_cost):
  - cand_cost < min_cost: slot0 ← cand_list; other slots ← 0; match_count ← 1; min_cost ← cand_cost; overflow ← 0.
  - cand_cost == min_cost and match_count < DEPTH: slot[match_count] ← cand_list; match_count + 1.
  - cand_cost == min_cost and match_count == DEPTH: candidate dropped; overflow ← 1 (sticky until the next start or a new lower minimum).
  - cand_cost > min_cost: no change.
- The first candidate of a search always lands in slot0. A first cost of all ones ties with the initial min_cost and is stored at count 0.
- COLLECT with search_done:
  - a candidate in the same cycle is processed first;
  - match_count > 0 → DRAIN with read pointer 0;
  - match_count == 0 → IDLE and done pulses.
- DRAIN:
  - out_valid = 1; out_list = slot[read pointer]; out_last = (read pointer == match_count-1).
  - On out_valid && out_ready: read pointer + 1.
  - If out_last was high on that transfer: next state IDLE, done pulses.
  - cand_valid and search_done are ignored.
- In IDLE, cand_valid, search_done and out_ready are ignored.
- min_cost, match_count and overflow hold their values after the drain until the next start or RST.

## Timing
- RST values: state IDLE; min_cost all ones; match_count 0; overflow 0; busy 0; out_valid 0; out_list 0; out_last 0; done 0; all slots 0; read pointer 0.
- Candidate update latency is 1 cycle: min_cost, match_count and overflow reflect a candidate on the edge after cand_valid. One candidate can be accepted per cycle, back-to-back.
- search_done at edge t: DRAIN is active and out_valid = 1 from t+1.
- Transfer rate is one list per cycle while out_ready is held high.
- out_list and out_last are stable while out_valid=1 and out_ready=0.
- done is high for exactly the cycle after the final transfer, or the cycle after search_done when match_count is 0.
- RST mid-DRAIN: next cycle is IDLE with all reset values; no done pulse.

## Structure
- Shared package holds:
  - state enum {IDLE, COLLECT, DRAIN};
  - list slicing helper function (entry k of a packed list).
- Sub-module list_regfile:
  - DEPTH × (N*IDXW) register file;
  - one write port, a clear-all input, a keep-slot0-clear-rest input, one asynchronous read port.
- The top module holds the FSM, the compare logic, the counters and the handshake.

## Test plan
- Strictly decreasing costs: RST, start, candidates with costs 50, 40, 30, then search_done → min_cost=30; match_count=1; a single transfer of the last list with out_last=1; then done.
- Ties with a new minimum: costs 20, 20, 20, 15, 15 → min_cost=15; match_count=2; drained lists are the 4th and 5th candidates, in arrival order.
- Overflow: DEPTH+2 candidates at cost 7 → match_count=DEPTH; overflow=1. A later candidate at cost 6 → match_count=1; overflow=0.
- Back-pressure: 3 stored lists, out_ready toggled 1,0,0,1,1 → each list is transferred exactly once; out_list is stable during stalls; done follows the third transfer.
- Same-cycle candidate and done: cand_valid with a tie, together with search_done → the tied list is included in the drain. Also: search_done with no candidates → done on the next cycle and out_valid never rises.
- Reset and restart:
  - RST asserted mid-DRAIN → all outputs return to their reset values;
  - start asserted mid-COLLECT → min_cost returns to all ones and match_count to 0.
